// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: fetch FSM states, reset vector and
// the opcode / function-code constants that fetch and control both decode against.
package mips_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StHold  = 2'd2,
      StHalt  = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // SPECIAL function codes (instr[5:0])
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // REGIMM b_code values (instr[20:16])
   localparam logic [4:0] BC_BLTZ   = 5'h00;
   localparam logic [4:0] BC_BGEZ   = 5'h01;
   localparam logic [4:0] BC_BLTZAL = 5'h10;
   localparam logic [4:0] BC_BGEZAL = 5'h11;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads one word per instruction over an
// Avalon-style bus, and holds the instruction register and its decoded fields
// steady for control/datapath until the datapath asks for the next one.
module instr_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic [31:0] pc_next,
   input  logic        advance,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  function_code,
   output logic [4:0]  b_code,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm16,
   output logic [25:0] instr_index,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic        fetch_fault
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         fault_q, fault_d;

   // State registers; reset drops avm_read immediately and discards any pending read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_VECTOR;
         instr_q <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         fault_q <= fault_d;
      end
   end

   // Next-state: advance only has effect in StHold; StHalt is absorbing until reset.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      fault_d = fault_q;
      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            if (!avm_waitrequest) begin
               instr_d = avm_readdata;
               state_d = StHold;
            end
         end
         StHold: begin
            if (advance) begin
               if (pc_next == 32'h0) begin
                  // Jump to 0 is the software halt convention.
                  pc_d    = 32'h0;
                  state_d = StHalt;
               end else if (pc_next[1:0] != 2'b00) begin
                  // Misaligned target: keep the faulting instruction's PC for diagnosis.
                  fault_d = 1'b1;
                  state_d = StHalt;
               end else begin
                  pc_d    = pc_next;
                  state_d = StFetch;
               end
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StHalt;
         end
      endcase
   end

   // Outputs come straight from registers; no path from advance or avm_readdata.
   always_comb begin
      avm_read    = (state_q == StFetch);
      avm_address = pc_q;
      instr_valid = (state_q == StHold);
      halted      = (state_q == StHalt);
      fetch_fault = fault_q;
      pc          = pc_q;
      pc_plus4    = pc_q + 32'd4;
      instr       = instr_q;
   end

   // Field extraction is plain slicing of the instruction register.
   always_comb begin
      opcode        = instr_q[31:26];
      rs            = instr_q[25:21];
      rt            = instr_q[20:16];
      b_code        = instr_q[20:16];
      rd            = instr_q[15:11];
      shamt         = instr_q[10:6];
      function_code = instr_q[5:0];
      imm16         = instr_q[15:0];
      instr_index   = instr_q[25:0];
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: accepted reads push the expected PC/word into
// a scoreboard, which is popped and compared once instr_valid rises.
module tb_instr_fetch;

   logic        clk;
   logic        reset_n;
   logic [31:0] avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic [31:0] pc_next;
   logic        advance;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  function_code;
   logic [4:0]  b_code;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [15:0] imm16;
   logic [25:0] instr_index;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        halted;
   logic        fetch_fault;

   instr_fetch #(.RESET_VECTOR(32'hBFC0_0000)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .pc_next         (pc_next),
      .advance         (advance),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .opcode          (opcode),
      .function_code   (function_code),
      .b_code          (b_code),
      .rs              (rs),
      .rt              (rt),
      .rd              (rd),
      .shamt           (shamt),
      .imm16           (imm16),
      .instr_index     (instr_index),
      .pc              (pc),
      .pc_plus4        (pc_plus4),
      .halted          (halted),
      .fetch_fault     (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_t;

   fetch_t sb[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Bounded wait (at negedges) for the DUT to raise avm_read.
   task automatic wait_read();
      int n = 0;
      while (avm_read !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("read_timeout", {31'h0, avm_read}, 32'h1);
   endtask

   // Serve one read after 'waits' wait cycles, then compare the held instruction.
   task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] word, input int waits);
      fetch_t e;
      wait_read();
      check("fetch_addr", avm_address, exp_pc);
      avm_readdata = word;
      for (int i = 0; i < waits; i++) begin
         avm_waitrequest = 1'b1;
         @(negedge clk);
         check("wait_read", {31'h0, avm_read}, 32'h1);
         check("wait_addr", avm_address, exp_pc);
         check("wait_valid", {31'h0, instr_valid}, 32'h0);
      end
      avm_waitrequest = 1'b0;
      sb.push_back('{pc: exp_pc, word: word});
      @(negedge clk);
      check("valid", {31'h0, instr_valid}, 32'h1);
      check("read_off", {31'h0, avm_read}, 32'h0);
      if (instr_valid === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         check("instr", instr, e.word);
         check("pc", pc, e.pc);
         check("pc_plus4", pc_plus4, e.pc + 32'd4);
         check("opcode", {26'h0, opcode}, {26'h0, e.word[31:26]});
         check("rs", {27'h0, rs}, {27'h0, e.word[25:21]});
         check("rt", {27'h0, rt}, {27'h0, e.word[20:16]});
         check("b_code", {27'h0, b_code}, {27'h0, e.word[20:16]});
         check("rd", {27'h0, rd}, {27'h0, e.word[15:11]});
         check("shamt", {27'h0, shamt}, {27'h0, e.word[10:6]});
         check("funct", {26'h0, function_code}, {26'h0, e.word[5:0]});
         check("imm16", {16'h0, imm16}, {16'h0, e.word[15:0]});
         check("index", {6'h0, instr_index}, {6'h0, e.word[25:0]});
      end
      // Bus data changing while in HOLD must not disturb the instruction register.
      avm_readdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("hold_instr", instr, word);
      check("hold_valid", {31'h0, instr_valid}, 32'h1);
   endtask

   task automatic do_advance(input logic [31:0] target);
      pc_next = target;
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      pc_next = 32'h1234_5678;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      avm_waitrequest = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_read", {31'h0, avm_read}, 32'h0);
      check("rst_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_halted", {31'h0, halted}, 32'h0);
      check("rst_fault", {31'h0, fetch_fault}, 32'h0);
      check("rst_pc", pc, 32'hBFC0_0000);
      reset_n = 1'b1;
      #1;
      check("idle_read", {31'h0, avm_read}, 32'h0);
      @(negedge clk);
      check("fetch_read", {31'h0, avm_read}, 32'h1);
      check("fetch_addr0", avm_address, 32'hBFC0_0000);
   endtask

   initial begin
      reset_n         = 1'b0;
      advance         = 1'b0;
      pc_next         = 32'h0;
      avm_readdata    = 32'h0;
      avm_waitrequest = 1'b0;
      @(negedge clk);
      check("rst_opcode", {26'h0, opcode}, 32'h0);
      check("rst_imm", {16'h0, imm16}, 32'h0);
      do_reset();

      // add $16,$17,$18 with zero wait
      do_fetch(32'hBFC0_0000, 32'h0232_8020, 0);
      check("add_rs", {27'h0, rs}, 32'd17);
      check("add_rt", {27'h0, rt}, 32'd18);
      check("add_rd", {27'h0, rd}, 32'd16);
      check("add_fn", {26'h0, function_code}, 32'h20);

      do_advance(32'hBFC0_0010);
      check("adv_pc", pc, 32'hBFC0_0010);
      check("adv_pc4", pc_plus4, 32'hBFC0_0014);
      check("adv_read", {31'h0, avm_read}, 32'h1);
      // advance in FETCH (with a halting target) must be ignored
      avm_waitrequest = 1'b1;
      do_advance(32'h0);
      check("ign_halt", {31'h0, halted}, 32'h0);
      check("ign_pc", pc, 32'hBFC0_0010);
      check("ign_read", {31'h0, avm_read}, 32'h1);

      // bgezal with three wait cycles
      do_fetch(32'hBFC0_0010, 32'h0411_FFFF, 3);
      check("bgezal_bc", {27'h0, b_code}, 32'd17);
      check("bgezal_imm", {16'h0, imm16}, 32'hFFFF);

      do_advance(32'hBFC0_0014);
      do_fetch(32'hBFC0_0014, 32'h8C88_0004, 1);

      // jump to 0 halts cleanly
      do_advance(32'h0);
      check("h0_halted", {31'h0, halted}, 32'h1);
      check("h0_fault", {31'h0, fetch_fault}, 32'h0);
      check("h0_pc", pc, 32'h0);
      check("h0_valid", {31'h0, instr_valid}, 32'h0);
      do_advance(32'hBFC0_0020);
      repeat (3) begin
         @(negedge clk);
         check("h0_noread", {31'h0, avm_read}, 32'h0);
      end
      check("h0_stay", pc, 32'h0);

      // PC wrap and misaligned fault
      do_reset();
      do_fetch(32'hBFC0_0000, 32'h3C01_1234, 0);
      do_advance(32'hFFFF_FFFC);
      check("wrap_pc4", pc_plus4, 32'h0);
      do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 1);
      do_advance(32'hBFC0_0006);
      check("mis_halted", {31'h0, halted}, 32'h1);
      check("mis_fault", {31'h0, fetch_fault}, 32'h1);
      check("mis_pc", pc, 32'hFFFF_FFFC);
      check("mis_read", {31'h0, avm_read}, 32'h0);

      // reset during a waited read aborts it
      do_reset();
      avm_waitrequest = 1'b1;
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_read", {31'h0, avm_read}, 32'h0);
      avm_readdata    = 32'hCAFE_F00D;
      avm_waitrequest = 1'b0;
      @(negedge clk);
      check("abort_instr", instr, 32'h0);
      check("abort_valid", {31'h0, instr_valid}, 32'h0);
      do_reset();
      do_fetch(32'hBFC0_0000, 32'h2402_0005, 0);

      check("sb_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
